// File: rtl/sync_fifo_if.sv
// Handshake/data bundle for sync_fifo: producer/consumer side is the master,
// the FIFO itself is the slave.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, data_count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses. No fall-through when empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  // A write at full is still taken when a read frees a slot on the same edge.
  always_comb begin
    wr_acc   = bus.wr_en && (!full_q || bus.rd_en);
    rd_acc   = bus.rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (ADDR_WIDTH+1)'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = bus.wr_en && full_q && !bus.rd_en;
    udf_d   = bus.rd_en && empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout       = dout_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.data_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, burst, fill/overflow, pointer wrap,
// simultaneous read/write at both boundaries, and asynchronous reset.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sync_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 16'h0000;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (10) cyc();
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
    checks++; if (bus.data_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.data_count); end
    checks++; if (bus.dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0b%0b exp=00", bus.overflow, bus.underflow); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_burst();
    for (int i = 1; i <= 6; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.data_count !== 4'd6) begin failures++; $display("FAIL burst_count got=%0d exp=6", bus.data_count); end
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++; if (bus.dout !== 16'(i)) begin failures++; $display("FAIL burst_dout%0d got=%h exp=%h", i, bus.dout, 16'(i)); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL burst_empty got=%0b exp=1", bus.empty); end
    checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL burst_no_udf got=%0b exp=0", bus.underflow); end
    cyc();
    checks++; if (bus.underflow !== 1'b1) begin failures++; $display("FAIL burst_udf got=%0b exp=1", bus.underflow); end
    checks++; if (bus.dout !== 16'h0006) begin failures++; $display("FAIL burst_hold got=%h exp=0006", bus.dout); end
    idle();
    cyc();
    checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL burst_udf_pulse got=%0b exp=0", bus.underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'h00A0 + 16'(i);
      cyc();
      if (i < 7) begin
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL fill_early_full%0d got=%0b exp=0", i, bus.full); end
      end
    end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
    checks++; if (bus.data_count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", bus.data_count); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0b exp=0", bus.empty); end
    bus.din = 16'hFFFF;
    cyc();
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%0b exp=1", bus.overflow); end
    checks++; if (bus.data_count !== 4'd8) begin failures++; $display("FAIL fill_ovf_count got=%0d exp=8", bus.data_count); end
    idle();
    cyc();
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_pulse got=%0b exp=0", bus.overflow); end
    checks++; if (bus.dout !== 16'h0006) begin failures++; $display("FAIL fill_dout_hold got=%h exp=0006", bus.dout); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (bus.dout !== 16'h00A0 + 16'(i)) begin failures++; $display("FAIL fill_drain%0d got=%h exp=%h", i, bus.dout, 16'h00A0 + 16'(i)); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fill_drained got=%0b exp=1", bus.empty); end
    idle();
    cyc();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'h0030 + 16'(i);
      cyc();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.dout !== 16'h0030 + 16'(i)) begin failures++; $display("FAIL wrap_pre%0d got=%h exp=%h", i, bus.dout, 16'h0030 + 16'(i)); end
    end
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'h0010 + 16'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0b exp=1", bus.full); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (bus.dout !== 16'h0010 + 16'(i)) begin failures++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, bus.dout, 16'h0010 + 16'(i)); end
    end
    checks++; if (bus.empty !== 1'b1 || bus.data_count !== 4'd0) begin failures++; $display("FAIL wrap_empty got=%0b/%0d exp=1/0", bus.empty, bus.data_count); end
    idle();
    cyc();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'h0020 + 16'(i);
      cyc();
    end
    bus.rd_en = 1'b1; bus.din = 16'h0055;
    cyc();
    checks++; if (bus.dout !== 16'h0020) begin failures++; $display("FAIL simul_full_dout got=%h exp=0020", bus.dout); end
    checks++; if (bus.full !== 1'b1 || bus.data_count !== 4'd8) begin failures++; $display("FAIL simul_full_stay got=%0b/%0d exp=1/8", bus.full, bus.data_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL simul_full_ovf got=%0b exp=0", bus.overflow); end
    bus.wr_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      checks++; if (bus.dout !== 16'h0020 + 16'(i)) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, bus.dout, 16'h0020 + 16'(i)); end
    end
    cyc();
    checks++; if (bus.dout !== 16'h0055) begin failures++; $display("FAIL simul_last got=%h exp=0055", bus.dout); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL simul_emptied got=%0b exp=1", bus.empty); end
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 16'h0066;
    cyc();
    checks++; if (bus.underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_udf got=%0b exp=1", bus.underflow); end
    checks++; if (bus.data_count !== 4'd1 || bus.empty !== 1'b0) begin failures++; $display("FAIL simul_empty_count got=%0d/%0b exp=1/0", bus.data_count, bus.empty); end
    checks++; if (bus.dout !== 16'h0055) begin failures++; $display("FAIL simul_no_fallthru got=%h exp=0055", bus.dout); end
    bus.wr_en = 1'b0;
    cyc();
    checks++; if (bus.dout !== 16'h0066 || bus.underflow !== 1'b0) begin failures++; $display("FAIL simul_rd66 got=%h/%0b exp=0066/0", bus.dout, bus.underflow); end
    idle();
    cyc();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.din = 16'h0040 + 16'(i);
      cyc();
    end
    idle();
    checks++; if (bus.data_count !== 4'd3) begin failures++; $display("FAIL arst_pre_count got=%0d exp=3", bus.data_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL arst_flags got=%0b/%0b exp=1/0", bus.empty, bus.full); end
    checks++; if (bus.data_count !== 4'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", bus.data_count); end
    checks++; if (bus.dout !== 16'h0000) begin failures++; $display("FAIL arst_dout got=%h exp=0000", bus.dout); end
    // Requests during reset must be ignored.
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 16'h0099;
    cyc();
    cyc();
    checks++; if (bus.data_count !== 4'd0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL arst_ignore got=%0d/%0b exp=0/0", bus.data_count, bus.underflow); end
    idle();
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.din = 16'h0077;
    cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    cyc();
    checks++; if (bus.dout !== 16'h0077) begin failures++; $display("FAIL arst_resume got=%h exp=0077", bus.dout); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL arst_resume_empty got=%0b exp=1", bus.empty); end
    idle();
    cyc();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
